// File: rtl/axil_reg_slave.sv
// AXI-Lite slave register bank: ID, scratch, control, status, IRQ and cycle-counter registers.
// One outstanding write and one outstanding read; the two channels run independently.
module axil_reg_slave #(
   parameter logic [31:0] ID_VALUE   = 32'h20250120,
   parameter logic [31:0] CTRL_RESET = 32'h00000000
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [14:0] s_awaddr,
   input  logic        s_awvalid,
   output logic        s_awready,
   input  logic [31:0] s_wdata,
   input  logic [3:0]  s_wstrb,
   input  logic        s_wvalid,
   output logic        s_wready,
   output logic [1:0]  s_bresp,
   output logic        s_bvalid,
   input  logic        s_bready,
   input  logic [14:0] s_araddr,
   input  logic        s_arvalid,
   output logic        s_arready,
   output logic [31:0] s_rdata,
   output logic [1:0]  s_rresp,
   output logic        s_rvalid,
   input  logic        s_rready,
   input  logic [31:0] status_in,
   input  logic [31:0] irq_pulse,
   output logic [31:0] ctrl_out,
   output logic        irq_out
);

   localparam logic [12:0] AddrId      = 13'h0;
   localparam logic [12:0] AddrScratch = 13'h1;
   localparam logic [12:0] AddrCtrl    = 13'h2;
   localparam logic [12:0] AddrStatus  = 13'h3;
   localparam logic [12:0] AddrIrqStat = 13'h4;
   localparam logic [12:0] AddrIrqEn   = 13'h5;
   localparam logic [12:0] AddrCycles  = 13'h6;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef enum logic {WIdle, WResp} w_state_e;
   typedef enum logic {RIdle, RResp} r_state_e;

   w_state_e    w_state_q, w_state_d;
   r_state_e    r_state_q, r_state_d;
   logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] scratch_q, scratch_d, ctrl_q, ctrl_d;
   logic [31:0] irq_stat_q, irq_stat_d, irq_en_q, irq_en_d;
   logic [31:0] cycles_q, cycles_d;
   logic        irq_out_q;

   logic        w_fire, ar_fire, w_err, rd_err;
   logic [31:0] wmask, irq_clr, rd_val;
   logic        addr_lsb_unused;

   assign addr_lsb_unused = ^{s_awaddr[1:0], s_araddr[1:0]};

   // Readies are gated by rstn so nothing is accepted while reset is held.
   assign s_awready = rstn && (w_state_q == WIdle) && s_awvalid && s_wvalid;
   assign s_wready  = s_awready;
   assign s_arready = rstn && (r_state_q == RIdle);
   assign w_fire    = s_awready;
   assign ar_fire   = s_arready && s_arvalid;

   assign wmask = {{8{s_wstrb[3]}}, {8{s_wstrb[2]}}, {8{s_wstrb[1]}}, {8{s_wstrb[0]}}};

   always_comb begin
      scratch_d = scratch_q;
      ctrl_d    = ctrl_q;
      irq_en_d  = irq_en_q;
      irq_clr   = '0;
      cycles_d  = cycles_q + 32'd1;
      w_err     = 1'b0;
      if (w_fire) begin
         case (s_awaddr[14:2])
            AddrScratch: scratch_d = (scratch_q & ~wmask) | (s_wdata & wmask);
            AddrCtrl:    ctrl_d    = (ctrl_q & ~wmask) | (s_wdata & wmask);
            AddrIrqStat: irq_clr   = s_wdata & wmask;
            AddrIrqEn:   irq_en_d  = (irq_en_q & ~wmask) | (s_wdata & wmask);
            AddrCycles:  cycles_d  = '0;
            AddrId, AddrStatus: ;
            default:     w_err     = 1'b1;
         endcase
      end
      // New events override a same-cycle clear.
      irq_stat_d = (irq_stat_q & ~irq_clr) | irq_pulse;
   end

   always_comb begin
      rd_err = 1'b0;
      case (s_araddr[14:2])
         AddrId:      rd_val = ID_VALUE;
         AddrScratch: rd_val = scratch_q;
         AddrCtrl:    rd_val = ctrl_q;
         AddrStatus:  rd_val = status_in;
         AddrIrqStat: rd_val = irq_stat_q;
         AddrIrqEn:   rd_val = irq_en_q;
         AddrCycles:  rd_val = cycles_q;
         default: begin
            rd_val = 32'hBADADD12;
            rd_err = 1'b1;
         end
      endcase
   end

   always_comb begin
      w_state_d = w_state_q;
      bvalid_d  = bvalid_q;
      bresp_d   = bresp_q;
      case (w_state_q)
         WIdle: if (w_fire) begin
            bvalid_d  = 1'b1;
            bresp_d   = w_err ? RespSlverr : RespOkay;
            w_state_d = WResp;
         end
         WResp: if (s_bready) begin
            bvalid_d  = 1'b0;
            w_state_d = WIdle;
         end
         default: w_state_d = WIdle;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      rvalid_d  = rvalid_q;
      rresp_d   = rresp_q;
      rdata_d   = rdata_q;
      case (r_state_q)
         RIdle: if (ar_fire) begin
            rvalid_d  = 1'b1;
            rdata_d   = rd_val;
            rresp_d   = rd_err ? RespSlverr : RespOkay;
            r_state_d = RResp;
         end
         RResp: if (s_rready) begin
            rvalid_d  = 1'b0;
            r_state_d = RIdle;
         end
         default: r_state_d = RIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         w_state_q  <= WIdle;
         r_state_q  <= RIdle;
         bvalid_q   <= 1'b0;
         bresp_q    <= RespOkay;
         rvalid_q   <= 1'b0;
         rresp_q    <= RespOkay;
         rdata_q    <= '0;
         scratch_q  <= '0;
         ctrl_q     <= CTRL_RESET;
         irq_stat_q <= '0;
         irq_en_q   <= '0;
         cycles_q   <= '0;
         irq_out_q  <= 1'b0;
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         scratch_q  <= scratch_d;
         ctrl_q     <= ctrl_d;
         irq_stat_q <= irq_stat_d;
         irq_en_q   <= irq_en_d;
         cycles_q   <= cycles_d;
         irq_out_q  <= |(irq_stat_q & irq_en_q);
      end
   end

   assign s_bvalid = bvalid_q;
   assign s_bresp  = bresp_q;
   assign s_rvalid = rvalid_q;
   assign s_rresp  = rresp_q;
   assign s_rdata  = rdata_q;
   assign ctrl_out = ctrl_q;
   assign irq_out  = irq_out_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave: register map, strobes, IRQ, handshakes, reset.
module tb_axil_reg_slave;

   localparam logic [31:0] IdValue   = 32'h20250120;
   localparam logic [31:0] CtrlReset = 32'h00000000;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [14:0] s_awaddr = '0;
   logic        s_awvalid = 1'b0;
   logic        s_awready;
   logic [31:0] s_wdata = '0;
   logic [3:0]  s_wstrb = '0;
   logic        s_wvalid = 1'b0;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready = 1'b0;
   logic [14:0] s_araddr = '0;
   logic        s_arvalid = 1'b0;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready = 1'b0;
   logic [31:0] status_in = '0;
   logic [31:0] irq_pulse = '0;
   logic [31:0] ctrl_out;
   logic        irq_out;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   axil_reg_slave #(.ID_VALUE(IdValue), .CTRL_RESET(CtrlReset)) dut (
      .clk(clk), .rstn(rstn),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .status_in(status_in), .irq_pulse(irq_pulse), .ctrl_out(ctrl_out), .irq_out(irq_out)
   );

   // Transactions start 1ns after a rising edge and end 1ns after the completing edge.
   task automatic do_write(input logic [14:0] a, input logic [31:0] d, input logic [3:0] st,
                           output logic [1:0] resp);
      int n;
      s_awaddr = a; s_wdata = d; s_wstrb = st; s_awvalid = 1'b1; s_wvalid = 1'b1;
      #1;
      n = 0;
      while (!s_awready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
      n = 0;
      while (!s_bvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL write_timeout addr=%h got bvalid=0 want bvalid=1", a);
      end
      resp = s_bresp;
      @(posedge clk); #1;
      s_bready = 1'b0;
   endtask

   task automatic do_read(input logic [14:0] a, output logic [31:0] d, output logic [1:0] resp,
                          output logic lat_ok);
      int n;
      s_araddr = a; s_arvalid = 1'b1;
      #1;
      n = 0;
      while (!s_arready && n < 50) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      lat_ok = s_rvalid;
      n = 0;
      while (!s_rvalid && n < 50) begin @(posedge clk); #1; n++; end
      if (n >= 50) begin
         total++; bad++;
         $display("FAIL read_timeout addr=%h got rvalid=0 want rvalid=1", a);
      end
      d = s_rdata; resp = s_rresp;
      s_rready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0;
   endtask

   task automatic test_reset();
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++;
      if ({s_awready, s_wready, s_arready} !== 3'b000) begin
         bad++; $display("FAIL reset_ready got=%b want=000", {s_awready, s_wready, s_arready});
      end
      total++;
      if ({s_bvalid, s_rvalid, s_bresp, s_rresp, irq_out} !== 7'b0) begin
         bad++; $display("FAIL reset_valid got=%b want=0000000",
                         {s_bvalid, s_rvalid, s_bresp, s_rresp, irq_out});
      end
      total++;
      if (s_rdata !== 32'h0 || ctrl_out !== CtrlReset) begin
         bad++; $display("FAIL reset_regs got rdata=%h ctrl=%h want 0/%h", s_rdata, ctrl_out,
                         CtrlReset);
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      rstn = 1'b1;
      @(posedge clk); #1;
      total++;
      if (s_arready !== 1'b1 || s_awready !== 1'b0) begin
         bad++; $display("FAIL idle_ready got ar=%b aw=%b want 1/0", s_arready, s_awready);
      end
   endtask

   task automatic test_scratch();
      logic [1:0] br, rr; logic [31:0] rd; logic lat;
      do_write(15'h0004, 32'hA5A55A5A, 4'hF, br);
      do_read(15'h0004, rd, rr, lat);
      total++;
      if (br !== 2'b00) begin bad++; $display("FAIL scratch_bresp got=%b want=00", br); end
      total++;
      if (rd !== 32'hA5A55A5A || rr !== 2'b00) begin
         bad++; $display("FAIL scratch_read got=%h/%b want=a5a55a5a/00", rd, rr);
      end
      total++;
      if (lat !== 1'b1) begin bad++; $display("FAIL read_latency got rvalid=%b want=1", lat); end
   endtask

   task automatic test_ctrl_strb();
      logic [1:0] br, rr; logic [31:0] rd; logic lat;
      do_write(15'h0008, 32'hFFFFFFFF, 4'h3, br);
      total++;
      if (ctrl_out !== 32'h0000FFFF) begin
         bad++; $display("FAIL ctrl_strb got=%h want=0000ffff", ctrl_out);
      end
      do_read(15'h0000, rd, rr, lat);
      total++;
      if (rd !== IdValue || rr !== 2'b00) begin
         bad++; $display("FAIL id_read got=%h/%b want=%h/00", rd, rr, IdValue);
      end
   endtask

   task automatic test_unmapped();
      logic [1:0] br, rr; logic [31:0] rd; logic lat;
      do_read(15'h0100, rd, rr, lat);
      total++;
      if (rd !== 32'hBADADD12 || rr !== 2'b10) begin
         bad++; $display("FAIL unmapped_read got=%h/%b want=badadd12/10", rd, rr);
      end
      do_write(15'h0100, 32'h12345678, 4'hF, br);
      total++;
      if (br !== 2'b10) begin bad++; $display("FAIL unmapped_bresp got=%b want=10", br); end
      do_write(15'h0000, 32'h0, 4'hF, br);
      total++;
      if (br !== 2'b00) begin bad++; $display("FAIL ro_bresp got=%b want=00", br); end
      do_read(15'h0000, rd, rr, lat);
      total++;
      if (rd !== IdValue) begin bad++; $display("FAIL ro_id got=%h want=%h", rd, IdValue); end
      do_read(15'h0004, rd, rr, lat);
      total++;
      if (rd !== 32'hA5A55A5A) begin
         bad++; $display("FAIL unmapped_side_effect got=%h want=a5a55a5a", rd);
      end
      status_in = 32'hCAFEF00D;
      do_read(15'h000C, rd, rr, lat);
      total++;
      if (rd !== 32'hCAFEF00D || rr !== 2'b00) begin
         bad++; $display("FAIL status_read got=%h/%b want=cafef00d/00", rd, rr);
      end
   endtask

   task automatic test_irq();
      logic [1:0] br, rr; logic [31:0] rd; logic lat;
      irq_pulse = 32'h8;
      @(posedge clk); #1;
      irq_pulse = 32'h0;
      do_write(15'h0014, 32'h8, 4'hF, br);
      total++;
      if (irq_out !== 1'b1) begin bad++; $display("FAIL irq_assert got=%b want=1", irq_out); end
      // W1C of bit 3 on the same edge as a fresh pulse on bit 3
      s_awaddr = 15'h0010; s_wdata = 32'h8; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1; irq_pulse = 32'h8;
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; irq_pulse = 32'h0; s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
      do_read(15'h0010, rd, rr, lat);
      total++;
      if (rd !== 32'h8) begin bad++; $display("FAIL irq_set_wins got=%h want=00000008", rd); end
      do_write(15'h0010, 32'h8, 4'hF, br);
      total++;
      if (irq_out !== 1'b0) begin bad++; $display("FAIL irq_clear got=%b want=0", irq_out); end
      do_read(15'h0010, rd, rr, lat);
      total++;
      if (rd !== 32'h0) begin bad++; $display("FAIL irq_w1c got=%h want=00000000", rd); end
   endtask

   task automatic test_handshake();
      logic [1:0] rr; logic [31:0] rd; logic lat; logic seen;
      s_awaddr = 15'h0004; s_wdata = 32'h11111111; s_wstrb = 4'hF; s_awvalid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (s_awready !== 1'b0 || s_wready !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL lone_awvalid got ready=1 want=0"); end
      s_wvalid = 1'b1;
      #1;
      total++;
      if ({s_awready, s_wready} !== 2'b11) begin
         bad++; $display("FAIL joint_ready got=%b want=11", {s_awready, s_wready});
      end
      @(posedge clk); #1;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (s_bvalid !== 1'b1 || s_awready !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      total++;
      if (seen !== 1'b0) begin bad++; $display("FAIL bvalid_hold got drop/reaccept want hold"); end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1;
      @(posedge clk); #1;
      s_bready = 1'b0;
      total++;
      if (s_bvalid !== 1'b0) begin bad++; $display("FAIL bvalid_done got=1 want=0"); end
      do_read(15'h0004, rd, rr, lat);
      total++;
      if (rd !== 32'h11111111) begin bad++; $display("FAIL hs_write got=%h want=11111111", rd); end
   endtask

   task automatic test_back_to_back();
      logic [1:0] br, rr; logic [31:0] rd; logic lat;
      s_awaddr = 15'h0004; s_wdata = 32'h22222222; s_wstrb = 4'hF;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_araddr = 15'h0004; s_arvalid = 1'b1;
      @(posedge clk); #1;
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      total++;
      if (s_rvalid !== 1'b1 || s_rdata !== 32'h11111111) begin
         bad++; $display("FAIL rw_same_cycle got=%b/%h want=1/11111111", s_rvalid, s_rdata);
      end
      s_rready = 1'b1; s_bready = 1'b1;
      @(posedge clk); #1;
      s_rready = 1'b0; s_bready = 1'b0;
      do_read(15'h0004, rd, rr, lat);
      total++;
      if (rd !== 32'h22222222) begin bad++; $display("FAIL rw_after got=%h want=22222222", rd); end
      // Clear lands on the handshake edge; one more edge elapses before the read samples.
      do_write(15'h0018, 32'h0000FFFF, 4'h1, br);
      do_read(15'h0018, rd, rr, lat);
      total++;
      if (rd !== 32'h1 || br !== 2'b00) begin
         bad++; $display("FAIL cycles_clear got=%h/%b want=00000001/00", rd, br);
      end
   endtask

   task automatic test_reset_mid();
      logic [1:0] br, rr; logic [31:0] rd; logic lat;
      do_write(15'h0008, 32'h000000F0, 4'hF, br);
      s_araddr = 15'h0004; s_arvalid = 1'b1;
      @(posedge clk); #1;
      s_arvalid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (s_rvalid !== 1'b1) begin bad++; $display("FAIL pre_reset_rvalid got=0 want=1"); end
      rstn = 1'b0;
      #1;
      total++;
      if (s_rvalid !== 1'b0 || ctrl_out !== CtrlReset || s_arready !== 1'b0) begin
         bad++; $display("FAIL mid_reset got rvalid=%b ctrl=%h arready=%b want 0/%h/0",
                         s_rvalid, ctrl_out, s_arready, CtrlReset);
      end
      @(posedge clk); #1;
      rstn = 1'b1;
      @(posedge clk); #1;
      do_read(15'h0004, rd, rr, lat);
      total++;
      if (rd !== 32'h0 || rr !== 2'b00 || lat !== 1'b1) begin
         bad++; $display("FAIL post_reset_read got=%h/%b/%b want=00000000/00/1", rd, rr, lat);
      end
   endtask

   initial begin
      test_reset();
      test_scratch();
      test_ctrl_strb();
      test_unmapped();
      test_irq();
      test_handshake();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
